sfp_tx_arbiter: RTL and testbench

- Shares the single 64-bit SFP TX AXI-Stream link (toward the SFP core, 199.998 MHz domain) between four on-chip sources:
  - ch0: master command
  - ch1: peer-forward FIFO
  - ch2: local-forward FIFO
  - ch3: slave response
- Round-robin arbitration with burst locking, so one source's multi-beat message is never interleaved with another's.
- Registered output stage; gated by the SFP enable bit from the AXI4-Lite register block.

---
 rtl/sfp_tx_arbiter.sv | 147 ++++++++++++++
 tb/tb_sfp_tx_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sfp_tx_arbiter.sv
// Round-robin arbiter that shares the SFP TX AXI-Stream link between several requesters.
// A grant is held for a whole burst (until the requester gaps or P_MAX_BURST beats pass),
// and beats go through a single registered output stage toward the SFP core.
module sfp_tx_arbiter #(
  parameter int unsigned P_CH_NUM     = 4,
  parameter int unsigned P_DATA_WIDTH = 64,
  parameter int unsigned P_MAX_BURST  = 16
) (
  input  logic                             i_clk,
  input  logic                             i_rst,
  input  logic                             i_sfp_en,
  input  logic [P_CH_NUM*P_DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [P_CH_NUM-1:0]              s_axis_tvalid,
  output logic [P_CH_NUM-1:0]              s_axis_tready,
  output logic [P_DATA_WIDTH-1:0]          m_axis_tdata,
  output logic                             m_axis_tvalid,
  input  logic                             m_axis_tready,
  output logic [P_CH_NUM-1:0]              o_grant,
  output logic                             o_busy,
  output logic [7:0]                       o_beat_cnt
);

  localparam int unsigned IdxW = (P_CH_NUM > 1) ? $clog2(P_CH_NUM) : 1;

  typedef enum logic [0:0] {StIdle, StXfer} state_e;

  state_e                  state_q, state_d;
  logic [IdxW-1:0]         gidx_q, gidx_d;
  logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
  logic [P_CH_NUM-1:0]     grant_q, grant_d;
  logic [7:0]              beat_cnt_q, beat_cnt_d;
  logic                    m_valid_q, m_valid_d;
  logic [P_DATA_WIDTH-1:0] m_data_q, m_data_d;

  logic                    pick_found;
  logic [IdxW-1:0]         pick_idx;
  logic [IdxW:0]           cand;
  logic                    out_ok;
  logic                    g_valid;
  logic [P_DATA_WIDTH-1:0] g_data;
  logic                    accept;
  logic [IdxW-1:0]         next_ptr;

  // Cyclic search for the first valid requester starting at rr_ptr.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned i = 0; i < P_CH_NUM; i++) begin
      cand = {1'b0, rr_ptr_q} + (IdxW+1)'(i);
      if (cand >= (IdxW+1)'(P_CH_NUM)) begin
        cand = cand - (IdxW+1)'(P_CH_NUM);
      end
      if (!pick_found && s_axis_tvalid[cand[IdxW-1:0]]) begin
        pick_found = 1'b1;
        pick_idx   = cand[IdxW-1:0];
      end
    end
  end

  // Granted-channel view, handshake and per-channel ready.
  always_comb begin
    out_ok   = !m_valid_q || m_axis_tready;
    g_valid  = s_axis_tvalid[gidx_q];
    g_data   = s_axis_tdata[32'(gidx_q) * P_DATA_WIDTH +: P_DATA_WIDTH];
    accept   = (state_q == StXfer) && out_ok && g_valid;
    next_ptr = (gidx_q == IdxW'(P_CH_NUM - 1)) ? '0 : gidx_q + IdxW'(1);
    s_axis_tready = '0;
    if (state_q == StXfer) begin
      s_axis_tready[gidx_q] = out_ok;
    end
  end

  // Next-state: arbitration in idle, beat transfer and burst release in xfer.
  always_comb begin
    state_d    = state_q;
    gidx_d     = gidx_q;
    rr_ptr_d   = rr_ptr_q;
    grant_d    = grant_q;
    beat_cnt_d = beat_cnt_q;
    m_valid_d  = m_valid_q;
    m_data_d   = m_data_q;
    unique case (state_q)
      StIdle: begin
        // A beat left over from the previous burst drains here.
        if (m_axis_tready) begin
          m_valid_d = 1'b0;
        end
        if (i_sfp_en && pick_found) begin
          state_d           = StXfer;
          gidx_d            = pick_idx;
          grant_d           = '0;
          grant_d[pick_idx] = 1'b1;
          beat_cnt_d        = '0;
        end
      end
      StXfer: begin
        if (accept) begin
          m_data_d   = g_data;
          m_valid_d  = 1'b1;
          beat_cnt_d = beat_cnt_q + 8'd1;
          // Forced release once the burst limit is reached.
          if (beat_cnt_q == 8'(P_MAX_BURST - 1)) begin
            state_d  = StIdle;
            grant_d  = '0;
            rr_ptr_d = next_ptr;
          end
        end else if (out_ok) begin
          // Output free but requester has a gap: its burst is over.
          m_valid_d = 1'b0;
          state_d   = StIdle;
          grant_d   = '0;
          rr_ptr_d  = next_ptr;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q    <= StIdle;
      gidx_q     <= '0;
      rr_ptr_q   <= '0;
      grant_q    <= '0;
      beat_cnt_q <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
    end else begin
      state_q    <= state_d;
      gidx_q     <= gidx_d;
      rr_ptr_q   <= rr_ptr_d;
      grant_q    <= grant_d;
      beat_cnt_q <= beat_cnt_d;
      m_valid_q  <= m_valid_d;
      m_data_q   <= m_data_d;
    end
  end

  assign m_axis_tdata  = m_data_q;
  assign m_axis_tvalid = m_valid_q;
  assign o_grant       = grant_q;
  assign o_beat_cnt    = beat_cnt_q;
  assign o_busy        = (state_q == StXfer) || m_valid_q;

endmodule

// File: tb/tb_sfp_tx_arbiter.sv
// Self-checking bench for sfp_tx_arbiter: transaction-level model checked every cycle,
// plus literal expectations on delivered beats and grant order for each scenario.
module tb_sfp_tx_arbiter;

  localparam int N  = 4;
  localparam int W  = 64;
  localparam int MB = 16;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           en;
  logic [N*W-1:0] s_tdata;
  logic [N-1:0]   s_tvalid;
  logic [N-1:0]   s_tready;
  logic [W-1:0]   m_tdata;
  logic           m_tvalid;
  logic           m_tready;
  logic [N-1:0]   grant;
  logic           busy;
  logic [7:0]     beat_cnt;

  always #5 clk = ~clk;

  sfp_tx_arbiter #(
    .P_CH_NUM    (N),
    .P_DATA_WIDTH(W),
    .P_MAX_BURST (MB)
  ) dut (
    .i_clk        (clk),
    .i_rst        (rst_n),
    .i_sfp_en     (en),
    .s_axis_tdata (s_tdata),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .o_grant      (grant),
    .o_busy       (busy),
    .o_beat_cnt   (beat_cnt)
  );

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_en  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Sources: each channel streams src_left beats with incrementing data.
  int          src_left[N];
  logic [63:0] src_val[N];

  task automatic drive_src();
    for (int c = 0; c < N; c++) begin
      s_tvalid[c]         = (src_left[c] > 0);
      s_tdata[c*W +: W]   = src_val[c];
    end
  endtask

  task automatic tick();
    logic [N-1:0] hs;
    @(negedge clk);
    hs = s_tvalid & s_tready;
    @(posedge clk);
    #1;
    for (int c = 0; c < N; c++) begin
      if (hs[c]) begin
        src_val[c]  = src_val[c] + 1;
        src_left[c] = src_left[c] - 1;
      end
    end
    drive_src();
  endtask

  // Model: who holds the link, how many beats it has sent, what sits in the output slot.
  bit          md_x;
  int          md_ch;
  int          md_cnt;
  int          md_ptr;
  bit          md_ov;
  logic [63:0] md_od;

  task automatic model_step();
    bit ok;
    if (!rst_n) begin
      md_x = 0; md_ch = 0; md_cnt = 0; md_ptr = 0; md_ov = 0; md_od = '0;
    end else if (!md_x) begin
      if (md_ov && m_tready) md_ov = 0;
      if (en && s_tvalid != '0) begin
        for (int k = N - 1; k >= 0; k--) begin
          if (s_tvalid[(md_ptr + k) % N]) md_ch = (md_ptr + k) % N;
        end
        md_x   = 1;
        md_cnt = 0;
      end
    end else begin
      ok = !md_ov || m_tready;
      if (ok && s_tvalid[md_ch]) begin
        md_od  = s_tdata[md_ch*W +: W];
        md_ov  = 1;
        md_cnt = md_cnt + 1;
        if (md_cnt == MB) begin
          md_x   = 0;
          md_ptr = (md_ch + 1) % N;
        end
      end else if (ok) begin
        md_ov  = 0;
        md_x   = 0;
        md_ptr = (md_ch + 1) % N;
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Observation logs for literal checks.
  logic [63:0]  out_q[$];
  logic [N-1:0] g_log[$];
  logic [N-1:0] prev_g = '0;
  bit           prev_stall = 0;
  logic [63:0]  prev_data = '0;

  // Per-cycle comparison against the model, sampled mid-cycle.
  initial forever begin
    logic [N-1:0] exp_g;
    logic [N-1:0] exp_r;
    @(negedge clk);
    if (chk_en) begin
      exp_g = md_x ? N'(1 << md_ch) : '0;
      exp_r = (md_x && (!md_ov || m_tready)) ? N'(1 << md_ch) : '0;
      chk("m_tvalid", m_tvalid, md_ov);
      chk("m_tdata", m_tdata, md_od);
      chk("s_tready", s_tready, exp_r);
      chk("o_grant", grant, exp_g);
      chk("o_busy", busy, md_x || md_ov);
      chk("o_beat_cnt", beat_cnt, md_cnt);
      if (prev_stall && rst_n) begin
        chk("stall_hold_valid", m_tvalid, 1);
        chk("stall_hold_data", m_tdata, prev_data);
      end
      if (m_tvalid && m_tready) out_q.push_back(m_tdata);
      if (grant != '0 && grant != prev_g) g_log.push_back(grant);
    end
    prev_g     = grant;
    prev_stall = m_tvalid && !m_tready;
    prev_data  = m_tdata;
  end

  task automatic do_reset();
    rst_n    = 1'b0;
    m_tready = 1'b1;
    for (int c = 0; c < N; c++) begin
      src_left[c] = 0;
      src_val[c]  = '0;
    end
    drive_src();
    tick();
    tick();
    rst_n = 1'b1;
    out_q.delete();
    g_log.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bit done;
    rst_n = 1'b0; en = 1'b0; m_tready = 1'b1; s_tdata = '0; s_tvalid = '0;
    for (int c = 0; c < N; c++) begin src_left[c] = 0; src_val[c] = '0; end
    do_reset();
    chk_en = 1;

    // Reset state and a single 3-beat burst from ch2.
    chk("rst_grant", grant, 0);
    chk("rst_tvalid", m_tvalid, 0);
    chk("rst_cnt", beat_cnt, 0);
    en = 1'b1;
    src_left[2] = 3; src_val[2] = 64'hA0; drive_src();
    tick();
    chk("t1_grant_ch2", grant, 4'b0100);
    repeat (8) tick();
    chk("t1_nbeats", out_q.size(), 3);
    for (int i = 0; i < 3; i++) chk("t1_beat", out_q[i], 64'hA0 + 64'(i));
    chk("t1_cnt", beat_cnt, 3);
    chk("t1_grant_idle", grant, 0);
    chk("t1_rr_ptr", md_ptr, 3);

    // Round-robin fairness with all channels continuously valid.
    do_reset();
    en = 1'b1;
    for (int c = 0; c < N; c++) begin src_left[c] = 40; src_val[c] = 64'((c + 1) << 12); end
    drive_src();
    repeat (75) tick();
    for (int c = 0; c < N; c++) src_left[c] = 0;
    drive_src();
    repeat (5) tick();
    chk("t2_ngrants", g_log.size() >= 5, 1);
    for (int i = 0; i < 5; i++) chk("t2_grant_order", g_log[i], 4'b0001 << (i % 4));
    chk("t2_nbeats", out_q.size() >= 65, 1);
    for (int i = 0; i < 64; i++) chk("t2_beat", out_q[i], 64'((((i / 16) + 1) << 12) + (i % 16)));
    chk("t2_beat64", out_q[64], 64'h1010);

    // Backpressure from the SFP side.
    do_reset();
    en = 1'b1;
    src_left[0] = 5; src_val[0] = 64'h50; drive_src();
    for (int i = 0; i < 30; i++) begin
      m_tready = (i % 4 == 0) || (i % 4 == 3);
      tick();
    end
    m_tready = 1'b1;
    repeat (3) tick();
    chk("t3_nbeats", out_q.size(), 5);
    for (int i = 0; i < 5; i++) chk("t3_beat", out_q[i], 64'h50 + 64'(i));

    // Enable gating.
    do_reset();
    en = 1'b0;
    src_left[1] = 4; src_val[1] = 64'h70; drive_src();
    repeat (5) tick();
    chk("t4_no_grant", grant, 0);
    chk("t4_no_out", out_q.size(), 0);
    chk("t4_no_valid", m_tvalid, 0);
    en = 1'b1;
    src_left[3] = 3; src_val[3] = 64'h30; drive_src();
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = (out_q.size() >= 2);
    end
    chk("t4_two_beats_wait", done, 1);
    en = 1'b0;
    repeat (15) tick();
    chk("t4_nbeats", out_q.size(), 4);
    for (int i = 0; i < 4; i++) chk("t4_beat", out_q[i], 64'h70 + 64'(i));
    chk("t4_ngrants", g_log.size(), 1);
    chk("t4_grant_ch1", g_log[0], 4'b0010);
    chk("t4_ch3_unserved", src_left[3], 3);
    chk("t4_grant_idle", grant, 0);

    // Reset during a burst.
    do_reset();
    en = 1'b1;
    src_left[1] = 8; src_val[1] = 64'h80; drive_src();
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = (out_q.size() >= 3);
    end
    chk("t5_three_beats_wait", done, 1);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_tvalid", m_tvalid, 0);
    chk("t5_rst_tready", s_tready, 0);
    chk("t5_rst_grant", grant, 0);
    chk("t5_rst_cnt", beat_cnt, 0);
    rst_n = 1'b1;
    src_left[0] = 2; src_val[0] = 64'h90; drive_src();
    g_log.delete();
    repeat (10) tick();
    chk("t5_first_after_rst", g_log[0], 4'b0001);
    chk("t5_second_after_rst", g_log[1], 4'b0010);

    // Gap release: ch3 loses its grant on a tvalid gap.
    do_reset();
    en = 1'b1;
    src_left[3] = 2; src_val[3] = 64'hC0; drive_src();
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      tick();
      done = (src_left[3] == 0);
    end
    chk("t6_ch3_two_beats_wait", done, 1);
    src_left[0] = 1; src_val[0] = 64'hD0; drive_src();
    tick();
    src_left[3] = 2; drive_src();
    repeat (12) tick();
    chk("t6_ngrants", g_log.size(), 3);
    chk("t6_grant0", g_log[0], 4'b1000);
    chk("t6_grant1", g_log[1], 4'b0001);
    chk("t6_grant2", g_log[2], 4'b1000);
    chk("t6_nbeats", out_q.size(), 5);
    chk("t6_beat0", out_q[0], 64'hC0);
    chk("t6_beat1", out_q[1], 64'hC1);
    chk("t6_beat2", out_q[2], 64'hD0);
    chk("t6_beat3", out_q[3], 64'hC2);
    chk("t6_beat4", out_q[4], 64'hC3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
